// File: rtl/add8_pkg.sv
// Shared definitions for the FA8 accumulation front-end.
package add8_pkg;

    localparam int DATA_W = 8;

    // Explicit encodings; 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/add8_accum_ctrl_fa8.sv
// FA8: 8-bit ripple-carry adder, purely combinational.
module FA8
    import add8_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Ci,
    output logic [DATA_W-1:0] Y,
    output logic              Co
);

    logic [DATA_W:0] c;

    // Bitwise full-adder chain, carry rippling from bit 0 upward.
    always_comb begin
        c    = '0;
        Y    = '0;
        c[0] = Ci;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            Y[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Co = c[DATA_W];
    end

endmodule

// File: rtl/add8_accum_ctrl.sv
// add8_accum_ctrl: streams N_OPS operands through FA8, accumulating a mod-256
// total and a sticky carry, then offers the result over a valid/ready port.
module add8_accum_ctrl
    import add8_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cin,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  acc;
    logic               sticky;
    logic [CNT_W-1:0]   cnt;
    logic               cin_q;
    logic               start_go;
    logic               beat;

    logic [DATA_W-1:0]  fa_y;
    logic               fa_co;
    logic               fa_ci;

    // Carry-in only enters on the first add of an accumulation.
    assign fa_ci = (cnt == '0) ? cin_q : 1'b0;

    FA8 u_fa8 (
        .A  (acc),
        .B  (in_data),
        .Ci (fa_ci),
        .Y  (fa_y),
        .Co (fa_co)
    );

    // Next-state and handshake decode; illegal encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        start_go  = 1'b0;
        beat      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_go  = 1'b1;
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                beat     = in_valid;
                if (in_valid && (cnt == LAST_IDX)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and accumulator datapath; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            cin_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_go) begin
                acc    <= '0;
                sticky <= 1'b0;
                cnt    <= '0;
                cin_q  <= cin;
            end else if (beat) begin
                acc    <= fa_y;
                sticky <= sticky | fa_co;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    assign sum       = acc;
    assign carry_out = sticky;
    assign op_count  = cnt;

endmodule

// File: tb/tb_add8_accum_ctrl.sv
// Scoreboard bench for add8_accum_ctrl: stimulus pushes expected results
// computed from the operand list, a negedge monitor pops and compares.
module tb_add8_accum_ctrl;

    localparam int N = 4;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  sum;
    logic        carry_out;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic       held = 1'b0;
    logic [7:0] held_sum;
    logic       held_c;

    add8_accum_ctrl #(.N_OPS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare at the handshake, check hold stability otherwise.
    always @(negedge clk) begin
        if (reset) begin
            held <= 1'b0;
        end else if (out_valid) begin
            if (out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", int'(sum), int'(e.s));
                    chk("carry_out", int'(carry_out), int'(e.c));
                    chk("op_count", int'(op_count), e.n);
                end
                held <= 1'b0;
            end else if (held) begin
                chk("hold_sum", int'(sum), int'(held_sum));
                chk("hold_carry", int'(carry_out), int'(held_c));
            end else begin
                held     <= 1'b1;
                held_sum <= sum;
                held_c   <= carry_out;
            end
        end
    end

    function automatic logic [3:0][7:0] mk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic send_beat(input logic [7:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic collect(input int hold, input bit pulse);
        int k;
        out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        out_ready = 1'b1;
        start     = pulse;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("idle_in_ready2", int'(in_ready), 0);
    endtask

    task automatic run_acc(input logic c, input logic [3:0][7:0] ops,
                           input int gap, input int hold, input bit pulse);
        int   total;
        exp_t e;
        total = int'(c);
        for (int i = 0; i < N; i++) total += int'(ops[i]);
        start = 1'b1;
        cin   = c;
        @(posedge clk); #1;
        start = 1'b0;
        cin   = 1'b0;
        for (int i = 0; i < N; i++) begin
            start = pulse;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            send_beat(ops[i]);
            if (i < N - 1) chk("no_early_valid", int'(out_valid), 0);
        end
        start = 1'b0;
        e.s = 8'(total % 256);
        e.c = (total > 255);
        e.n = N;
        q.push_back(e);
        chk("latency_out_valid", int'(out_valid), 1);
        collect(hold, pulse);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_carry", int'(carry_out), 0);
        chk("rst_op_count", int'(op_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_acc(1'b0, mk(8'd10, 8'd20, 8'd30, 8'd40), 0, 0, 1'b0);
        run_acc(1'b1, mk(8'd200, 8'd100, 8'd0, 8'd0), 0, 0, 1'b0);
        run_acc(1'b1, mk(8'd255, 8'd0, 8'd0, 8'd0), 0, 0, 1'b0);
        run_acc(1'b0, mk(8'd10, 8'd20, 8'd30, 8'd40), 3, 5, 1'b0);

        // abort after two beats
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(8'd10);
        send_beat(8'd20);
        chk("mid_op_count", int'(op_count), 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_op_count", int'(op_count), 0);
        run_acc(1'b0, mk(8'd1, 8'd1, 8'd1, 8'd1), 0, 0, 1'b0);

        // start pulses in ACCUM and in the DONE handshake cycle
        run_acc(1'b1, mk(8'd7, 8'd9, 8'd250, 8'd3), 1, 2, 1'b1);

        for (int v = 0; v < 16; v++) begin
            logic [3:0][7:0] ops;
            for (int i = 0; i < N; i++) ops[i] = 8'($urandom);
            run_acc(1'($urandom), ops, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
